// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, state type, SubBytes FSM encoding
// and the forward S-box table with its lookup helper.
package aes_pkg;

  localparam int unsigned AES_BYTES = 16;

  typedef logic [8*AES_BYTES-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } subbytes_state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

endpackage

// File: rtl/aes_subbytes_serial_rsbox.sv
// RSBox: registered AES S-box lookup, one cycle latency, no reset.
// Ports: clk - clock; din - byte to substitute; dout - S(din) from previous edge.
module RSBox
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Output is meaningless until the first lookup after a block starts.
  always_ff @(posedge clk) begin
    dout <= sbox_lookup(din);
  end

endmodule

// File: rtl/aes_subbytes_serial.sv
// aes_subbytes_serial: byte-serial AES SubBytes. Accepts a block over
// in_valid/in_ready, streams its bytes one per cycle through a single RSBox,
// reassembles the result and offers it over out_valid/out_ready.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_state input
// handshake; out_valid/out_ready/out_state output handshake; busy high
// while a block is in flight or waiting to be taken.
// Byte k of a state lives at [8*NBYTES-1-8k -: 8] (byte 0 most significant).
module aes_subbytes_serial
  import aes_pkg::*;
#(
  parameter int unsigned NBYTES = AES_BYTES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_state,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_state,
  output logic                busy
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned CW = $clog2(NBYTES + 1);

  subbytes_state_e state;
  logic [W-1:0]    src_q;
  logic [CW-1:0]   cnt;
  logic [7:0]      sbox_in;
  logic [7:0]      sbox_q;

  // S-box source byte selected by cnt, clamped to the last byte so the
  // lookup input is always a defined register value.
  always_comb begin
    sbox_in = src_q[7:0];
    for (int k = 0; k < int'(NBYTES) - 1; k++) begin
      if (cnt == CW'(k)) sbox_in = src_q[W-1-8*k -: 8];
    end
  end

  RSBox u_rsbox (
    .clk  (clk),
    .din  (sbox_in),
    .dout (sbox_q)
  );

  // Control FSM; the result byte for cnt-1 lands one cycle behind its lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src_q     <= '0;
      out_state <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src_q    <= in_state;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < int'(NBYTES); k++) begin
            if (cnt == CW'(k + 1)) out_state[W-1-8*k -: 8] <= sbox_q;
          end
          // cnt stops at NBYTES so it cannot wrap for any NBYTES.
          if (cnt == CW'(NBYTES)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// Self-checking bench for aes_subbytes_serial: FIPS vectors, backpressure,
// back-to-back, busy-input immunity, mid-run reset and random blocks checked
// against an S-box built from GF(2^8) inversion plus the affine map.
module tb_aes_subbytes_serial;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [7:0] ref_sbox [256];

  aes_subbytes_serial #(.NBYTES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_subbytes(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = ref_sbox[s[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts at a negedge in IDLE; ends at the negedge after the output
  // handshake with in_valid set for an optional queued follow-up block.
  task automatic run_block(input logic [127:0] d, input int stall, input bit chk_lat,
                           input bit chk_period, input bit next_valid,
                           input logic [127:0] next_d);
    logic [127:0] exp;
    int n;
    exp = ref_subbytes(d);
    in_valid = 1'b1;
    in_state = d;
    out_ready = 1'b0;
    chk("accept_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    if (chk_period) chk("b2b_period", 128'(cyc - last_acc), 128'(19));
    last_acc = cyc;
    @(negedge clk);
    chk("busy_run", 128'({busy, in_ready}), 128'(2'b10));
    n = 0;
    while (1) begin
      in_valid = 1'($urandom);
      in_state = rand128();
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
      if (n > 40) begin
        chk("timeout_out_valid", 128'(out_valid), 128'(1));
        break;
      end
    end
    in_valid = next_valid;
    in_state = next_valid ? next_d : rand128();
    if (chk_lat) chk("latency", 128'(n), 128'(17));
    chk("result", out_state, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_state", out_state, exp);
      chk("hold_flags", 128'({out_valid, in_ready, busy}), 128'(3'b101));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_handshake", 128'({out_valid, in_ready, busy}), 128'(3'b010));
  endtask

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    for (int i = 0; i < 256; i++) ref_sbox[i] = model_sbox(8'(i));
    rst = 1'b1;
    in_valid = 1'b0;
    in_state = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("reset_out_state", out_state, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    chk("model_fips", ref_subbytes(128'h193de3bea0f4e22b9ac68d2ae9f84808),
        128'hd42711aee0bf98f1b8b45de51e415230);

    run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 1'b1, 1'b0, 1'b0, '0);
    chk("fips_vector", out_state, 128'hd42711aee0bf98f1b8b45de51e415230);

    run_block(128'h0, 2, 1'b1, 1'b0, 1'b0, '0);
    chk("zero_vector", out_state, 128'h63636363636363636363636363636363);

    // Backpressure, then a queued block taken right after the handshake.
    a = rand128();
    run_block(128'h000102030405060708090a0b0c0d0e0f, 10, 1'b1, 1'b0, 1'b1, a);
    chk("bp_vector", out_state, 128'h637c777bf26b6fc53001672bfed7ab76);
    run_block(a, 0, 1'b1, 1'b0, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100);
    run_block(128'h0f0e0d0c0b0a09080706050403020100, 0, 1'b1, 1'b1, 1'b0, '0);

    // Reset while cnt is 8.
    in_valid = 1'b1;
    in_state = rand128();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("midrst_out_state", out_state, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_output", 128'({in_ready, out_valid}), 128'(2'b10));
    run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 1'b1, 1'b0, 1'b0, '0);

    // Random blocks, mixed stalls, chained back-to-back.
    b = rand128();
    for (int i = 0; i < 8; i++) begin
      a = b;
      b = rand128();
      run_block(a, int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b1, b);
    end
    run_block(b, 0, 1'b1, 1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_subbytes_serial.md
# aes_subbytes_serial

Byte-serial AES SubBytes stage that sits directly upstream of the registered S-box lookup (`RSBox`). It accepts a full 128-bit AES state over a valid/ready handshake and feeds its 16 bytes one per cycle into a single `RSBox` instance. It reassembles the substituted bytes into a 128-bit result, which it presents to the downstream round logic over a second valid/ready handshake.

## Interface
Parameters:
- `NBYTES`, default 16: bytes per block; state width is 8*NBYTES.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream offers a block.
- `in_ready`  out  1  block can be accepted.
- `in_state`  in  8*NBYTES  input state; byte k = `in_state[8*NBYTES-1-8k -: 8]` (byte 0 is most significant, FIPS-197 order).
- `out_valid`  out  1  substituted block available.
- `out_ready`  in  1  downstream consumes the block.
- `out_state`  out  8*NBYTES  substituted state, same byte order.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `in_state` into the source register, clear counter `cnt`, and go to RUN.
- RUN (`cnt` = 0..NBYTES):
  - If `cnt` < NBYTES, the S-box input is source byte `cnt`. The S-box registers S(byte `cnt`) at the edge.
  - If `cnt` >= 1, result byte `cnt`-1 is loaded from the S-box output at the edge.
  - Each RUN cycle ends with `cnt`++.
  - At the edge with `cnt`==NBYTES: go to DONE.
- DONE:
  - `out_valid`=1 and `out_state` is held stable.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0; there is no overlap of input and output.
- The S-box has no reset, so its output is don't-care outside RUN. It is sampled only when `cnt` >= 1.
- `in_state` is sampled only at acceptance. Changes afterwards have no effect.
- In IDLE and RUN the S-box input is driven with the source byte selected by `cnt`, clamped to byte NBYTES-1. The S-box input is never driven X.
- `cnt` width is `$clog2(NBYTES+1)`. It never wraps within a block.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0.
  - `out_state`=0, source register=0, `cnt`=0.
- Acceptance edge t0 → `out_valid` rises after edge t0+NBYTES+1 (17 cycles at NBYTES=16).
- Back-to-back throughput: one block per NBYTES+3 cycles when `out_ready` is held high (19 at NBYTES=16). This covers the IDLE accept cycle, NBYTES+1 RUN cycles, and the DONE handshake cycle.
- `out_valid` stays high with constant `out_state` while `out_ready`=0, for any number of cycles.
- `in_valid` while not `in_ready` is ignored. The upstream must hold the block until the handshake.
- Reset asserted mid-RUN or mid-DONE:
  - Return to IDLE immediately and clear all registers.
  - The in-flight block is dropped and no partial `out_valid` is produced.
- `out_state` is not cleared on the DONE→IDLE transition. It keeps its last value, but only has meaning while `out_valid`=1.

## Structure
- Shared package `aes_pkg`:
  - `AES_BYTES`=16.
  - Typedef `aes_state_t` (logic [127:0]).
  - FSM state enum `subbytes_state_e` {IDLE, RUN, DONE}.
- One sub-module: `RSBox` (registered lookup, 1-cycle latency, no reset), instantiated once. All other logic stays in this module.

## Test plan
- **Reset default:** check `in_ready`=1, `out_valid`=0, `out_state`=0.
- **FIPS-197 round-1 vector:**
  - Stimulus: input 193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: `out_state`=d42711aee0bf98f1b8b45de51e415230, with `out_valid` rising exactly 17 cycles after acceptance.
- **All-zero input:** all-zero state → 63636363636363636363636363636363.
- **Backpressure and back-to-back:**
  - Input 000102030405060708090a0b0c0d0e0f with `out_ready`=0 for 10 cycles.
  - Required: output 637c777bf26b6fc53001672bfed7ab76 is held stable and `in_ready`=0 throughout.
  - Then release `out_ready` with a second block queued. The second block is accepted 1 cycle after the handshake.
- **Input ignored when busy:** toggle `in_valid` and change `in_state` during RUN → result unaffected, no extra acceptance.
- **Reset mid-operation:**
  - Assert `rst` at `cnt`=8.
  - Required: immediate IDLE, `out_valid`=0, `out_state`=0.
  - The next block completes correctly.
